// File: rtl/grizzly_isa_pkg.sv
// Grizzly541A ISA constants shared by the instruction encoder and the core decoder.
// Opcode values and the bit positions of each field in the 16-bit instruction word.
package grizzly_isa_pkg;

    localparam logic [2:0] OP_ARITH   = 3'b000;
    localparam logic [2:0] OP_LOGIC   = 3'b001;
    localparam logic [2:0] OP_BRANCH  = 3'b010;
    localparam logic [2:0] OP_CALL    = 3'b011;
    localparam logic [2:0] OP_PUSH    = 3'b100;
    localparam logic [2:0] OP_LDI     = 3'b101;
    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_LDR     = 3'b111;

    localparam int INSTR_W    = 16;

    localparam int OPC_LSB    = 0;
    localparam int OPC_MSB    = 2;
    localparam int FUNC_LSB   = 3;
    localparam int FUNC_MSB   = 4;
    localparam int LDIREG_LSB = 3;
    localparam int LDIREG_MSB = 7;
    localparam int IMM_LSB    = 8;
    localparam int IMM_MSB    = 15;
    localparam int RS1_LSB    = 5;
    localparam int RS1_MSB    = 9;
    localparam int RS2_LSB    = 10;
    localparam int RS2_MSB    = 14;

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through FIFO of encoded instruction words with an occupancy count.
// Push is ignored when full and pop is ignored when empty, so callers may drive them freely.
module instr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;

    // Head is read combinationally so a new word is visible the cycle after it is written.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs field-level requests into Grizzly541A instruction words and queues them in a FWFT FIFO.
// Illegal-opcode requests are consumed without being queued and raise a sticky flag.
module instruction_encoder #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          InValid,
    output logic          InReady,
    input  logic [2:0]    InOpcode,
    input  logic [1:0]    InFunc,
    input  logic [4:0]    InRegA,
    input  logic [4:0]    InRegB,
    input  logic [7:0]    InImm,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [15:0]   OutInstr,
    output logic [CW-1:0] Count,
    output logic          IllegalOp,
    input  logic          ErrClear,
    output logic [15:0]   EncodedTotal
);

    import grizzly_isa_pkg::*;

    logic [INSTR_W-1:0] w_word;
    logic               w_accept;
    logic               w_is_illegal;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               r_illegal;
    logic [15:0]        r_total;

    always_comb begin
        w_word = '0;
        w_word[OPC_MSB:OPC_LSB] = InOpcode;
        case (InOpcode)
            OP_ARITH, OP_LOGIC, OP_LDR: begin
                w_word[FUNC_MSB:FUNC_LSB] = InFunc;
                w_word[RS1_MSB:RS1_LSB]   = InRegA;
                w_word[RS2_MSB:RS2_LSB]   = InRegB;
            end
            OP_LDI: begin
                w_word[LDIREG_MSB:LDIREG_LSB] = InRegA;
                w_word[IMM_MSB:IMM_LSB]       = InImm;
            end
            OP_BRANCH, OP_CALL: begin
                w_word[FUNC_MSB:FUNC_LSB] = InFunc;
                w_word[IMM_MSB:IMM_LSB]   = InImm;
            end
            OP_PUSH: begin
                w_word[RS1_MSB:RS1_LSB] = InRegA;
            end
            default: begin
                w_word = '0;
            end
        endcase
    end

    // Ready depends on occupancy only; a simultaneous pop does not open a slot for a full FIFO.
    assign InReady      = !w_full;
    assign w_accept     = InValid && InReady;
    assign w_is_illegal = (InOpcode == OP_ILLEGAL);
    assign w_push       = w_accept && !w_is_illegal;
    assign w_pop        = OutValid && OutReady;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (OutValid),
        .o_data  (OutInstr),
        .o_count (Count)
    );

    // A new illegal accept outranks a clear in the same cycle.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_illegal <= 1'b0;
            r_total   <= '0;
        end else begin
            if (w_accept && w_is_illegal) begin
                r_illegal <= 1'b1;
            end else if (ErrClear) begin
                r_illegal <= 1'b0;
            end
            if (w_push) begin
                r_total <= r_total + 16'd1;
            end
        end
    end

    assign IllegalOp    = r_illegal;
    assign EncodedTotal = r_total;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: the driver queues expected words from a field-level
// reference model, and a negedge monitor compares FIFO head, occupancy and status against it.
module tb_instruction_encoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clock;
    logic          ResetN;
    logic          InValid;
    logic          InReady;
    logic [2:0]    InOpcode;
    logic [1:0]    InFunc;
    logic [4:0]    InRegA;
    logic [4:0]    InRegB;
    logic [7:0]    InImm;
    logic          OutValid;
    logic          OutReady;
    logic [15:0]   OutInstr;
    logic [CW-1:0] Count;
    logic          IllegalOp;
    logic          ErrClear;
    logic [15:0]   EncodedTotal;

    instruction_encoder #(.DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .InValid      (InValid),
        .InReady      (InReady),
        .InOpcode     (InOpcode),
        .InFunc       (InFunc),
        .InRegA       (InRegA),
        .InRegB       (InRegB),
        .InImm        (InImm),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutInstr     (OutInstr),
        .Count        (Count),
        .IllegalOp    (IllegalOp),
        .ErrClear     (ErrClear),
        .EncodedTotal (EncodedTotal)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    int          m_total  = 0;
    int          m_ill    = 0;
    bit          rand_mode = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference encoding built from field weights: bit position p contributes value * 2**p.
    function automatic logic [15:0] ref_encode(input int opc, input int fn, input int ra,
                                               input int rb, input int imm);
        int w;
        case (opc)
            0, 1, 7: w = opc + fn * 8 + ra * 32 + rb * 1024;
            5:       w = opc + ra * 8 + imm * 256;
            2, 3:    w = opc + fn * 8 + imm * 256;
            4:       w = opc + ra * 32;
            default: w = 0;
        endcase
        return 16'(w);
    endfunction

    // Monitor: compare visible state against the model, then retire the head on a pop.
    always @(negedge Clock) begin
        if (ResetN) begin
            check("count", int'(Count), exp_q.size());
            check("in_ready", int'(InReady), int'(exp_q.size() != DEPTH));
            check("out_valid", int'(OutValid), int'(exp_q.size() != 0));
            check("word", int'(OutInstr), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
            check("total", int'(EncodedTotal), m_total);
            check("illegal_op", int'(IllegalOp), m_ill);
            if (OutValid && OutReady && exp_q.size() != 0) begin
                $display("pop  word=%04h count=%0d", OutInstr, Count);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_edge(input bit acc, input bit clr, input logic [15:0] word, input bit ill);
        if (acc && ill) m_ill = 1;
        else if (clr) m_ill = 0;
        if (acc && !ill) begin
            exp_q.push_back(word);
            m_total = (m_total + 1) % 65536;
        end
    endtask

    task automatic randomize_ready();
        if (rand_mode) begin
            OutReady = ($urandom_range(0, 3) != 0);
            ErrClear = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic issue(input logic [2:0] opc, input logic [1:0] fn, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [7:0] imm);
        bit acc;
        bit clr;
        int waited;
        logic [15:0] word;
        word = ref_encode(int'(opc), int'(fn), int'(ra), int'(rb), int'(imm));
        InValid = 1'b1; InOpcode = opc; InFunc = fn; InRegA = ra; InRegB = rb; InImm = imm;
        waited = 0;
        acc = 0;
        while (!acc && waited < 100) begin
            @(negedge Clock);
            acc = InReady;
            clr = ErrClear;
            @(posedge Clock);
            #1;
            model_edge(acc, clr, word, opc == 3'b110);
            if (acc) $display("req  opc=%0d fn=%0d ra=%0d rb=%0d imm=%02h exp=%04h", opc, fn, ra, rb, imm, word);
            randomize_ready();
            waited++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit clr;
        InValid = 1'b0;
        repeat (n) begin
            @(negedge Clock);
            clr = ErrClear;
            @(posedge Clock);
            #1;
            model_edge(1'b0, clr, 16'h0, 1'b0);
            randomize_ready();
        end
    endtask

    initial begin
        ResetN = 1'b0; InValid = 1'b0; InOpcode = '0; InFunc = '0; InRegA = '0;
        InRegB = '0; InImm = '0; OutReady = 1'b0; ErrClear = 1'b0;
        #1;
        check("rst_out_valid", int'(OutValid), 0);
        check("rst_count", int'(Count), 0);
        check("rst_in_ready", int'(InReady), 1);
        check("rst_out_instr", int'(OutInstr), 0);
        check("rst_illegal", int'(IllegalOp), 0);
        check("rst_total", int'(EncodedTotal), 0);
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;

        // Directed encodings.
        issue(3'b101, 2'd0, 5'd5, 5'd0, 8'hA7);
        InValid = 1'b0;
        @(negedge Clock);
        check("ldi_word", int'(OutInstr), 16'hA72D);
        check("ldi_total", int'(EncodedTotal), 1);
        @(posedge Clock); #1;
        OutReady = 1'b1;
        issue(3'b000, 2'd2, 5'd3, 5'd7, 8'hFF);
        issue(3'b100, 2'd3, 5'd31, 5'd9, 8'h55);
        issue(3'b010, 2'd1, 5'd12, 5'd4, 8'h10);
        issue(3'b111, 2'd3, 5'd17, 5'd30, 8'h01);
        issue(3'b011, 2'd2, 5'd1, 5'd1, 8'hC3);
        issue(3'b001, 2'd1, 5'd8, 5'd16, 8'h00);
        idle(3);

        // Fill, stall the fifth request, single pop, then drain.
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) issue(3'b101, 2'd0, 5'(i), 5'd0, 8'(8'h30 + i));
        InValid = 1'b1; InOpcode = 3'b001; InFunc = 2'd2; InRegA = 5'd9; InRegB = 5'd10;
        repeat (3) @(posedge Clock);
        #1 OutReady = 1'b1;
        @(posedge Clock);
        #1 OutReady = 1'b0;
        issue(3'b001, 2'd2, 5'd9, 5'd10, 8'h00);
        OutReady = 1'b1;
        idle(6);

        // Streaming with one word resident.
        issue(3'b100, 2'd0, 5'd1, 5'd0, 8'h00);
        for (int i = 0; i < 10; i++) issue(3'b000, 2'(i), 5'(i + 2), 5'(20 - i), 8'hEE);
        idle(3);

        // Illegal opcode handling and clear priority.
        issue(3'b110, 2'd1, 5'd1, 5'd1, 8'h11);
        idle(2);
        ErrClear = 1'b1;
        idle(1);
        ErrClear = 1'b0;
        issue(3'b110, 2'd0, 5'd0, 5'd0, 8'h00);
        ErrClear = 1'b1;
        issue(3'b110, 2'd2, 5'd2, 5'd2, 8'h22);
        ErrClear = 1'b0;
        idle(2);

        // Randomised traffic with random backpressure and clears.
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_mode = 0;
        ErrClear = 1'b0;

        // Asynchronous reset between edges with three words resident.
        OutReady = 1'b1;
        idle(8);
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) issue(3'b010, 2'd3, 5'd0, 5'd0, 8'(i));
        InValid = 1'b0;
        #1 ResetN = 1'b0;
        #1;
        check("arst_out_valid", int'(OutValid), 0);
        check("arst_count", int'(Count), 0);
        check("arst_in_ready", int'(InReady), 1);
        check("arst_total", int'(EncodedTotal), 0);
        check("arst_out_instr", int'(OutInstr), 0);
        exp_q.delete();
        m_total = 0;
        m_ill = 0;
        #1 ResetN = 1'b1;
        issue(3'b101, 2'd0, 5'd5, 5'd0, 8'hA7);
        InValid = 1'b0;
        @(negedge Clock);
        check("post_rst_ldi", int'(OutInstr), 16'hA72D);
        @(posedge Clock); #1;
        OutReady = 1'b1;

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 50) begin
                idle(1);
                guard++;
            end
            if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
